// File: rtl/anc_fir_scheduler_if.sv
// Handshake and data bus between the ANC scheduler and the adaptive FIR weight engine.
interface anc_fir_scheduler_if;
    logic        fir_go;
    logic [31:0] fir_ff_in;
    logic [31:0] fir_weight_adjust;
    logic        fir_done;
    logic [31:0] fir_out;

    modport master (
        output fir_go, fir_ff_in, fir_weight_adjust,
        input  fir_done, fir_out
    );

    modport slave (
        input  fir_go, fir_ff_in, fir_weight_adjust,
        output fir_done, fir_out
    );
endinterface

// File: rtl/anc_fir_scheduler.sv
// Per-sample sequencer for the adaptive FIR: captures ref/err, computes the step-scaled
// weight adjustment, kicks the engine, and returns the saturated negated result.
module anc_fir_scheduler #(
    parameter int unsigned FRAC    = 15,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sample_valid,
    input  logic [31:0]            ref_sample,
    input  logic [31:0]            err_sample,
    input  logic [15:0]            mu,
    input  logic                   enable,
    input  logic                   adapt_en,
    anc_fir_scheduler_if.master    fir,
    output logic [31:0]            anti_noise,
    output logic                   anti_valid,
    output logic                   busy,
    output logic [CNT_W-1:0]       overrun_cnt,
    output logic [CNT_W-1:0]       timeout_cnt
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CALC  = 2'd1;
    localparam logic [1:0] ISSUE = 2'd2;
    localparam logic [1:0] WAIT  = 2'd3;

    localparam logic signed [47:0] ADJ_MAX = 48'sh0000_7FFF_FFFF;
    localparam logic signed [47:0] ADJ_MIN = 48'shFFFF_8000_0000;

    logic [1:0]              state;
    logic [31:0]             ref_w;
    logic [31:0]             err_w;
    logic                    pend_full;
    logic [31:0]             pend_ref;
    logic [31:0]             pend_err;
    logic [WAIT_W-1:0]       wait_cnt;
    logic                    take;
    logic signed [47:0]      prod;
    logic signed [47:0]      shifted;
    logic [31:0]             adj_sat;
    logic [31:0]             neg_out;

    assign take     = enable && sample_valid;
    assign busy     = (state != IDLE);
    assign fir.fir_go = (state == ISSUE);

    always_comb begin
        prod    = 48'($signed(mu)) * 48'($signed(err_w));
        shifted = prod >>> FRAC;
        if (shifted > ADJ_MAX)
            adj_sat = 32'h7FFF_FFFF;
        else if (shifted < ADJ_MIN)
            adj_sat = 32'h8000_0000;
        else
            adj_sat = shifted[31:0];
        // Negating the most negative value would wrap back onto itself.
        neg_out = (fir.fir_out == 32'h8000_0000) ? 32'h7FFF_FFFF : (~fir.fir_out + 32'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                 <= IDLE;
            ref_w                 <= '0;
            err_w                 <= '0;
            pend_full             <= 1'b0;
            pend_ref              <= '0;
            pend_err              <= '0;
            wait_cnt              <= '0;
            fir.fir_ff_in         <= '0;
            fir.fir_weight_adjust <= '0;
            anti_noise            <= '0;
            anti_valid            <= 1'b0;
            overrun_cnt           <= '0;
            timeout_cnt           <= '0;
        end else begin
            anti_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // Pending pair runs first; a coincident new pair refills the freed slot.
                    if (pend_full) begin
                        ref_w <= pend_ref;
                        err_w <= pend_err;
                        state <= CALC;
                        if (take) begin
                            pend_ref <= ref_sample;
                            pend_err <= err_sample;
                        end else begin
                            pend_full <= 1'b0;
                        end
                    end else if (take) begin
                        ref_w <= ref_sample;
                        err_w <= err_sample;
                        state <= CALC;
                    end
                end
                CALC: begin
                    fir.fir_ff_in         <= ref_w;
                    fir.fir_weight_adjust <= adapt_en ? adj_sat : '0;
                    state                 <= ISSUE;
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (fir.fir_done) begin
                        anti_noise <= neg_out;
                        anti_valid <= 1'b1;
                        state      <= IDLE;
                    end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                        if (timeout_cnt != '1)
                            timeout_cnt <= timeout_cnt + CNT_W'(1);
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            if (busy && take) begin
                if (!pend_full) begin
                    pend_ref  <= ref_sample;
                    pend_err  <= err_sample;
                    pend_full <= 1'b1;
                end else if (overrun_cnt != '1) begin
                    overrun_cnt <= overrun_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/anc_fir_scheduler.md
Name: anc_fir_scheduler

Overview:
- Sequences the adaptive FIR weight engine once per audio sample: captures reference and error samples, computes the step-scaled weight adjustment, issues a one-cycle go, and waits for done.
- Returns the inverted FIR result as the anti-noise sample.
- Buffers one sample arriving during a run, counts overruns, and recovers from a hung FIR via a timeout.
- Sits between the sample-rate front end and the FIR engine.

Parameters:
FRAC, 15, fractional bits of mu and the adjustment product (Q.15)
TIMEOUT, 255, maximum cycles in WAIT before abort (must be > TAPS+4 of the engine)
CNT_W, 8, width of the overrun and timeout counters

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sample_valid  in  1  one-cycle strobe: new ref/err pair
ref_sample  in  32  signed reference (feedforward) sample
err_sample  in  32  signed error-mic sample
mu  in  16  signed step size, Q1.15
enable  in  1  0 = ignore sample_valid
adapt_en  in  1  0 = force weight adjustment to zero (freeze weights)
fir_go  out  1  one-cycle start pulse to the FIR engine
fir_ff_in  out  32  feedforward sample to the FIR engine
fir_weight_adjust  out  32  signed weight adjustment to the FIR engine
fir_done  in  1  FIR completion pulse
fir_out  in  32  FIR result, valid with fir_done
anti_noise  out  32  signed anti-noise sample, -fir_out saturated
anti_valid  out  1  one-cycle strobe for anti_noise
busy  out  1  high in every state except IDLE
overrun_cnt  out  CNT_W  saturating count of dropped samples
timeout_cnt  out  CNT_W  saturating count of aborted runs

Behaviour:
- Reset values: all outputs 0; state IDLE; pending buffer empty.
- Reset mid-run: abandons the run immediately. No anti_valid is issued for it.
- States and transitions:
  - IDLE: on (enable && sample_valid), or pending buffer full, load the working ref/err registers (the new sample takes priority over pending only when pending is empty), then go to CALC.
  - CALC (1 cycle):
    - prod = mu * err, a 48-bit signed product.
    - adj = prod >>> FRAC, arithmetic shift, saturated to 32-bit signed.
    - adj = 0 when adapt_en = 0 (adapt_en sampled in this cycle).
    - Register adj to fir_weight_adjust and ref to fir_ff_in. Go to ISSUE.
  - ISSUE (1 cycle): fir_go = 1. Clear the timeout counter. Go to WAIT.
  - WAIT:
    - fir_ff_in and fir_weight_adjust held stable for the whole run.
    - On fir_done: anti_noise <= sat32(-fir_out), i.e. 0x80000000 maps to 0x7FFFFFFF; anti_valid = 1 the next cycle. Go to IDLE.
    - If the counter reaches TIMEOUT without fir_done: timeout_cnt += 1 (saturating), no anti_valid, go to IDLE.
- Latency:
  - sample_valid at cycle 0 (IDLE) -> fir_go at cycle 2.
  - fir_done at cycle N -> anti_valid at cycle N+1.
- Pending buffer (depth 1):
  - sample_valid && enable while busy: if empty, store the pair and set full; if already full, drop the new pair and overrun_cnt += 1 (saturating).
  - In IDLE the pending pair is consumed first; a simultaneous new sample_valid is then stored into the freed buffer. Nothing is lost.
- sample_valid in the same cycle as fir_done: the sample goes to pending; the next run starts from IDLE the following cycle.
- enable = 0: new samples are ignored and not counted. An in-flight run completes, and the pending sample is still processed.
- fir_done outside WAIT: ignored.
- fir_go is never asserted while in WAIT.

Test Plan:
1. Basic run: ref=0x00001000, err=0x00004000, mu=0x4000, adapt_en=1 -> fir_go at +2 cycles, fir_weight_adjust=0x00002000, fir_ff_in=0x00001000; fir_done with fir_out=0x00000100 -> anti_valid next cycle, anti_noise=0xFFFFFF00.
2. Freeze and saturation:
   - adapt_en=0, err=0x7FFFFFFF -> fir_weight_adjust=0.
   - adapt_en=1, mu=0x8000, err=0x80000000 -> fir_weight_adjust=0x7FFFFFFF.
   - fir_out=0x80000000 -> anti_noise=0x7FFFFFFF.
3. Overrun: three sample_valid pulses during one WAIT -> first buffered, next two dropped, overrun_cnt=2; after done, buffered pair processed with its own ref value.
4. Timeout: FIR model never asserts done -> return to IDLE after TIMEOUT=255 WAIT cycles, timeout_cnt=1, no anti_valid; next sample runs normally.
5. Simultaneous events: sample_valid coincident with fir_done -> next fir_go exactly 3 cycles after done, no drop, overrun_cnt unchanged.
6. Reset mid-WAIT: rst_n low for 1 cycle -> all outputs 0, busy=0, pending cleared, no anti_valid for the abandoned run.
